// File: rtl/cpu_debug_ctrl_pkg.sv
// Shared definitions for the CPU debug sequencer: FSM encoding, display
// select codes and the width of the CPU status bundle.
package cpu_debug_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2,
      ST_BRK  = 2'd3
   } dbg_state_t;

   localparam logic [2:0] SEL_PC_IN  = 3'd0;
   localparam logic [2:0] SEL_PC_OUT = 3'd1;
   localparam logic [2:0] SEL_INSTR  = 3'd2;
   localparam logic [2:0] SEL_RF_RD1 = 3'd3;
   localparam logic [2:0] SEL_RF_RD2 = 3'd4;
   localparam logic [2:0] SEL_ALU_Y  = 3'd5;
   localparam logic [2:0] SEL_M_RD   = 3'd6;
   localparam logic [2:0] SEL_STATUS = 3'd7;

   // {Jump,Branch,RegDst,RegWrite,MemRead,MemtoReg,MemWrite,ALUSrc,zero,ALUOp[1:0]}
   localparam int STATUS_W = 11;

endpackage

// File: rtl/cpu_debug_ctrl_btn_sync_edge.sv
// Multi-stage synchroniser for an asynchronous board input, giving the
// synchronised level plus a registered one-cycle pulse on its 0->1 transition.
module btn_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   level_d;

   assign level = sync[SYNC_STAGES-1];

   // The pulse is registered so a pin edge reaches consumers SYNC_STAGES+1 clocks later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync    <= '0;
         level_d <= 1'b0;
         rise    <= 1'b0;
      end else begin
         sync    <= {sync[SYNC_STAGES-2:0], raw};
         level_d <= sync[SYNC_STAGES-1];
         rise    <= sync[SYNC_STAGES-1] & ~level_d;
      end
   end

endmodule

// File: rtl/cpu_debug_ctrl.sv
// Run/step/breakpoint sequencer for the single-cycle CPU, with the shared
// inspection address counter and a registered 32-bit status display.
module cpu_debug_ctrl
   import cpu_debug_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic                step,
   input  logic                inc,
   input  logic                dec,
   input  logic                bp_en,
   input  logic [DATA_W-1:0]   bp_addr,
   input  logic [2:0]          sel,
   input  logic [DATA_W-1:0]   pc_in,
   input  logic [DATA_W-1:0]   pc_out,
   input  logic [DATA_W-1:0]   instr,
   input  logic [DATA_W-1:0]   rf_rd1,
   input  logic [DATA_W-1:0]   rf_rd2,
   input  logic [DATA_W-1:0]   alu_y,
   input  logic [DATA_W-1:0]   m_rd,
   input  logic [STATUS_W-1:0] status,
   output logic                cpu_en,
   output logic [ADDR_W-1:0]   m_rf_addr,
   output logic [DATA_W-1:0]   disp_data,
   output logic                halted,
   output logic                bp_hit
);

   dbg_state_t        state, state_next;
   logic              run_lvl, run_rise, step_p, inc_p, dec_p;
   logic [2:0]        btn_level_unused;
   logic              bp_match;
   logic [DATA_W-1:0] disp_next;

   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_run  (.clk(clk), .rst(rst), .raw(run),  .level(run_lvl),             .rise(run_rise));
   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step (.clk(clk), .rst(rst), .raw(step), .level(btn_level_unused[0]), .rise(step_p));
   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_inc  (.clk(clk), .rst(rst), .raw(inc),  .level(btn_level_unused[1]), .rise(inc_p));
   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dec  (.clk(clk), .rst(rst), .raw(dec),  .level(btn_level_unused[2]), .rise(dec_p));

   // A still-set bp_hit masks the compare so resuming executes the breakpoint instruction.
   assign bp_match = bp_en && (pc_out == bp_addr) && !bp_hit;
   assign halted   = (state == ST_HALT) || (state == ST_BRK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_HALT;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      cpu_en     = 1'b0;
      case (state)
         ST_HALT: begin
            if (run_lvl)     state_next = ST_RUN;
            else if (step_p) state_next = ST_STEP;
         end
         ST_RUN: begin
            if (bp_match) begin
               state_next = ST_BRK;
            end else begin
               cpu_en = 1'b1;
               if (!run_lvl) state_next = ST_HALT;
            end
         end
         ST_STEP: begin
            cpu_en     = 1'b1;
            state_next = run_lvl ? ST_RUN : ST_HALT;
         end
         ST_BRK: begin
            if (step_p)        state_next = ST_STEP;
            else if (!run_lvl) state_next = ST_HALT;
            else if (run_rise) state_next = ST_RUN;
         end
         default: state_next = ST_HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    bp_hit <= 1'b0;
      else if (state_next == ST_BRK)              bp_hit <= 1'b1;
      else if (state == ST_RUN || state == ST_STEP) bp_hit <= 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 m_rf_addr <= '0;
      else if (inc_p && !dec_p) m_rf_addr <= m_rf_addr + ADDR_W'(1);
      else if (dec_p && !inc_p) m_rf_addr <= m_rf_addr - ADDR_W'(1);
   end

   always_comb begin
      disp_next = '0;
      case (sel)
         SEL_PC_IN:  disp_next = pc_in;
         SEL_PC_OUT: disp_next = pc_out;
         SEL_INSTR:  disp_next = instr;
         SEL_RF_RD1: disp_next = rf_rd1;
         SEL_RF_RD2: disp_next = rf_rd2;
         SEL_ALU_Y:  disp_next = alu_y;
         SEL_M_RD:   disp_next = m_rd;
         SEL_STATUS: disp_next = {state, bp_hit, {(DATA_W-3-STATUS_W){1'b0}}, status};
         default:    disp_next = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) disp_data <= '0;
      else     disp_data <= disp_next;
   end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed self-checking bench for cpu_debug_ctrl with a trivial PC model
// that advances by 4 whenever the sequencer enables the CPU.
module tb_cpu_debug_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0, step = 1'b0, inc = 1'b0, dec = 1'b0;
   logic        bp_en = 1'b0;
   logic [31:0] bp_addr = 32'h0;
   logic [2:0]  sel = 3'd0;
   logic [31:0] pc = 32'h0;
   logic [31:0] pc_in;
   logic [31:0] instr = 32'h0, rf_rd1 = 32'h0, rf_rd2 = 32'h0, alu_y = 32'h0, m_rd = 32'h0;
   logic [10:0] status = 11'h0;
   logic        cpu_en;
   logic [7:0]  m_rf_addr;
   logic [31:0] disp_data;
   logic        halted, bp_hit;

   int vec_count   = 0;
   int miscompares = 0;
   int en_count    = 0;
   int en_base;
   logic [31:0] exp_disp [0:7];

   assign pc_in = pc + 32'd4;

   cpu_debug_ctrl dut (
      .clk(clk), .rst(rst), .run(run), .step(step), .inc(inc), .dec(dec),
      .bp_en(bp_en), .bp_addr(bp_addr), .sel(sel),
      .pc_in(pc_in), .pc_out(pc), .instr(instr), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .alu_y(alu_y), .m_rd(m_rd), .status(status),
      .cpu_en(cpu_en), .m_rf_addr(m_rf_addr), .disp_data(disp_data),
      .halted(halted), .bp_hit(bp_hit)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst)         pc <= 32'h0;
      else if (cpu_en) pc <= pc + 32'd4;
   end

   always @(negedge clk) if (cpu_en) en_count++;

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vec_count++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic s, input logic i, input logic d, input int hold);
      step = s; inc = i; dec = d;
      tick(hold);
      step = 1'b0; inc = 1'b0; dec = 1'b0;
      tick(6);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic wait_bp();
      for (int k = 0; k < 40 && !bp_hit; k++) tick(1);
      check_output("bp_hit_set", 32'(bp_hit), 32'h1);
   endtask

   initial begin
      tick(2);
      check_output("rst_cpu_en", 32'(cpu_en), 32'h0);
      check_output("rst_addr", 32'(m_rf_addr), 32'h0);
      check_output("rst_disp", disp_data, 32'h0);
      check_output("rst_halted", 32'(halted), 32'h1);
      check_output("rst_bp_hit", 32'(bp_hit), 32'h0);
      rst = 1'b0;
      tick(2);

      // Single steps, with exact pin-to-enable latency on the first one
      en_base = en_count;
      step = 1'b1;
      tick(3);
      check_output("step_lat3", 32'(cpu_en), 32'h0);
      tick(1);
      check_output("step_lat4", 32'(cpu_en), 32'h1);
      tick(1);
      check_output("step_lat5", 32'(cpu_en), 32'h0);
      step = 1'b0;
      tick(6);
      check_output("step1_halted", 32'(halted), 32'h1);
      for (int k = 2; k <= 4; k++) begin
         apply_stimulus(1'b1, 1'b0, 1'b0, 6);
         check_output($sformatf("step%0d_halted", k), 32'(halted), 32'h1);
      end
      check_output("step_pc", pc, 32'h10);
      check_output("step_count", 32'(en_count - en_base), 32'd4);

      apply_stimulus(1'b0, 1'b0, 1'b1, 6);
      check_output("addr_dec_wrap", 32'(m_rf_addr), 32'hFF);
      apply_stimulus(1'b0, 1'b1, 1'b0, 6);
      check_output("addr_inc_wrap", 32'(m_rf_addr), 32'h00);
      apply_stimulus(1'b0, 1'b1, 1'b1, 6);
      check_output("addr_both0", 32'(m_rf_addr), 32'h00);
      apply_stimulus(1'b0, 1'b1, 1'b0, 6);
      check_output("addr_inc", 32'(m_rf_addr), 32'h01);
      apply_stimulus(1'b0, 1'b1, 1'b1, 6);
      check_output("addr_both1", 32'(m_rf_addr), 32'h01);
      apply_stimulus(1'b0, 1'b0, 1'b1, 6);
      check_output("addr_dec", 32'(m_rf_addr), 32'h00);

      instr  = 32'h8C080004;
      rf_rd1 = 32'h11111111;
      rf_rd2 = 32'h22222222;
      alu_y  = 32'h33333333;
      m_rd   = 32'h44444444;
      status = 11'h5A5;
      exp_disp = '{32'h00000014, 32'h00000010, 32'h8C080004, 32'h11111111,
                   32'h22222222, 32'h33333333, 32'h44444444, 32'h000005A5};
      for (int k = 0; k < 8; k++) begin
         sel = 3'(k);
         tick(1);
         check_output($sformatf("disp_sel%0d", k), disp_data, exp_disp[k]);
      end

      // Breakpoint at 0x0C from a fresh PC, then single-step past it
      pulse_reset();
      bp_en   = 1'b1;
      bp_addr = 32'h0C;
      en_base = en_count;
      run     = 1'b1;
      wait_bp();
      check_output("bp_pc", pc, 32'h0C);
      check_output("bp_cpu_en", 32'(cpu_en), 32'h0);
      check_output("bp_halted", 32'(halted), 32'h1);
      check_output("bp_exec_count", 32'(en_count - en_base), 32'd3);
      sel = 3'd7;
      tick(5);
      check_output("bp_pc_hold", pc, 32'h0C);
      check_output("disp_brk", disp_data, 32'hE00005A5);
      run = 1'b0;
      tick(6);
      check_output("brk_to_halt_sticky", 32'(bp_hit), 32'h1);
      check_output("disp_halt_bp", disp_data, 32'h200005A5);
      apply_stimulus(1'b1, 1'b0, 1'b0, 6);
      check_output("bp_step_pc", pc, 32'h10);
      check_output("bp_step_clear", 32'(bp_hit), 32'h0);
      check_output("bp_step_halted", 32'(halted), 32'h1);

      // Resuming with run from the breakpoint must execute past it
      pulse_reset();
      run = 1'b1;
      wait_bp();
      run = 1'b0;
      tick(6);
      run = 1'b1;
      tick(10);
      check_output("resume_past_bp", 32'(pc > 32'h0C), 32'h1);
      check_output("resume_bp_clear", 32'(bp_hit), 32'h0);
      check_output("resume_running", 32'(halted), 32'h0);
      run   = 1'b0;
      bp_en = 1'b0;
      tick(6);

      // Asynchronous reset in the middle of free-running
      pulse_reset();
      inc = 1'b1;
      tick(6);
      inc = 1'b0;
      run = 1'b1;
      tick(10);
      check_output("free_run_en", 32'(cpu_en), 32'h1);
      #3;
      rst = 1'b1;
      #2;
      check_output("async_rst_en", 32'(cpu_en), 32'h0);
      check_output("async_rst_addr", 32'(m_rf_addr), 32'h0);
      check_output("async_rst_disp", disp_data, 32'h0);
      check_output("async_rst_halted", 32'(halted), 32'h1);
      tick(1);
      rst = 1'b0;
      tick(2);
      check_output("resume_lat2", 32'(cpu_en), 32'h0);
      tick(1);
      check_output("resume_lat3", 32'(cpu_en), 32'h1);
      run = 1'b0;
      tick(6);

      // Glitch between clock edges, then a long hold
      en_base = en_count;
      @(posedge clk);
      #2 step = 1'b1;
      #3 step = 1'b0;
      tick(8);
      check_output("glitch_steps", 32'(en_count - en_base), 32'd0);
      en_base = en_count;
      step = 1'b1;
      tick(100);
      step = 1'b0;
      tick(8);
      check_output("held_steps", 32'(en_count - en_base), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
